// File: rtl/servant_spi_arb_pkg.sv
// Shared definitions for the SPI memory-port arbiter: FSM state encoding
// and the read data returned to a requester whose transaction timed out.
package servant_spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2,
    TURN = 2'd3
  } arb_state_t;

  localparam logic [31:0] ERR_RDT = 32'hFFFF_FFFF;

endpackage

// File: rtl/servant_spi_rr_pick.sv
// Combinational 2-way round-robin picker. On a tie the requester that was
// not served last wins; otherwise the single active requester wins.
module servant_spi_rr_pick (
  input  logic stb0,
  input  logic stb1,
  input  logic rr_last,
  output logic grant,
  output logic valid
);

  // grant=1 selects requester 1, valid flags that anyone is asking
  always_comb begin
    valid = stb0 | stb1;
    grant = (stb0 & stb1) ? ~rr_last : stb1;
  end

endmodule

// File: rtl/servant_spi_arbiter.sv
// Two-requester Wishbone-classic arbiter in front of the SPI memory port.
// One whole transaction is granted at a time, round-robin on ties, and the
// downstream ack is routed back only to the owner of the grant.
// Optional watchdog enabled by defining SPI_ARB_TIMEOUT_EN: a grant that
// sees no downstream ack within TIMEOUT_CYCLES is terminated with an error
// ack (read data all ones) and a one-cycle o_timeout pulse.
module servant_spi_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TW             = 13
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [31:0] i_wb_r0_adr,
  input  logic [31:0] i_wb_r0_dat,
  input  logic [3:0]  i_wb_r0_sel,
  input  logic        i_wb_r0_we,
  input  logic        i_wb_r0_stb,
  output logic [31:0] o_wb_r0_rdt,
  output logic        o_wb_r0_ack,
  input  logic [31:0] i_wb_r1_adr,
  input  logic [31:0] i_wb_r1_dat,
  input  logic [3:0]  i_wb_r1_sel,
  input  logic        i_wb_r1_we,
  input  logic        i_wb_r1_stb,
  output logic [31:0] o_wb_r1_rdt,
  output logic        o_wb_r1_ack,
  output logic [31:0] o_wb_spi_adr,
  output logic [31:0] o_wb_spi_dat,
  output logic [3:0]  o_wb_spi_sel,
  output logic        o_wb_spi_we,
  output logic        o_wb_spi_stb,
  input  logic [31:0] i_wb_spi_rdt,
  input  logic        i_wb_spi_ack,
  output logic        o_timeout
);

  import servant_spi_arb_pkg::*;

  arb_state_t state_reg, state_next;
  logic       rr_last_reg, rr_last_next;
  logic       pick_grant, pick_valid;
  logic       tmo_hit;

  servant_spi_rr_pick u_pick (
    .stb0    (i_wb_r0_stb),
    .stb1    (i_wb_r1_stb),
    .rr_last (rr_last_reg),
    .grant   (pick_grant),
    .valid   (pick_valid)
  );

`ifdef SPI_ARB_TIMEOUT_EN
  logic [TW-1:0] wdog_reg, wdog_next;

  // Watchdog counts cycles spent in a grant; every grant is entered from
  // IDLE, so clearing outside the grant states clears it on entry.
  always_comb begin
    wdog_next = '0;
    if (state_reg == GNT0 || state_reg == GNT1) begin
      wdog_next = wdog_reg + 1'b1;
    end
  end

  // Watchdog register
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      wdog_reg <= '0;
    end else begin
      wdog_reg <= wdog_next;
    end
  end

  assign tmo_hit = (wdog_reg == TW'(TIMEOUT_CYCLES));
`else
  logic [TW-1:0] unused_limit;
  assign unused_limit = TW'(TIMEOUT_CYCLES);
  assign tmo_hit      = 1'b0;
`endif

  // State and round-robin history register
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_reg   <= IDLE;
      rr_last_reg <= 1'b1;
    end else begin
      state_reg   <= state_next;
      rr_last_reg <= rr_last_next;
    end
  end

  // Next-state, downstream mux and ack routing. Completion by ack takes
  // priority over withdrawal, which takes priority over timeout.
  always_comb begin
    state_next   = state_reg;
    rr_last_next = rr_last_reg;
    o_wb_spi_adr = i_wb_r0_adr;
    o_wb_spi_dat = i_wb_r0_dat;
    o_wb_spi_sel = i_wb_r0_sel;
    o_wb_spi_we  = i_wb_r0_we;
    o_wb_spi_stb = 1'b0;
    o_wb_r0_ack  = 1'b0;
    o_wb_r1_ack  = 1'b0;
    o_wb_r0_rdt  = i_wb_spi_rdt;
    o_wb_r1_rdt  = i_wb_spi_rdt;
    o_timeout    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next = pick_grant ? GNT1 : GNT0;
        end
      end
      GNT0: begin
        o_wb_spi_stb = i_wb_r0_stb;
        if (i_wb_spi_ack) begin
          o_wb_r0_ack  = 1'b1;
          rr_last_next = 1'b0;
          state_next   = TURN;
        end else if (!i_wb_r0_stb) begin
          state_next = TURN;
        end else if (tmo_hit) begin
          o_wb_r0_ack  = 1'b1;
          o_wb_r0_rdt  = ERR_RDT;
          o_timeout    = 1'b1;
          o_wb_spi_stb = 1'b0;
          rr_last_next = 1'b0;
          state_next   = TURN;
        end
      end
      GNT1: begin
        o_wb_spi_adr = i_wb_r1_adr;
        o_wb_spi_dat = i_wb_r1_dat;
        o_wb_spi_sel = i_wb_r1_sel;
        o_wb_spi_we  = i_wb_r1_we;
        o_wb_spi_stb = i_wb_r1_stb;
        if (i_wb_spi_ack) begin
          o_wb_r1_ack  = 1'b1;
          rr_last_next = 1'b1;
          state_next   = TURN;
        end else if (!i_wb_r1_stb) begin
          state_next = TURN;
        end else if (tmo_hit) begin
          o_wb_r1_ack  = 1'b1;
          o_wb_r1_rdt  = ERR_RDT;
          o_timeout    = 1'b1;
          o_wb_spi_stb = 1'b0;
          rr_last_next = 1'b1;
          state_next   = TURN;
        end
      end
      TURN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
